// File: rtl/cache_control_if.sv
// Control bundle between the cache sequencer, the CPU request port, physical memory
// and the cache datapath. The master side is the sequencer; the slave side is everything around it.
interface cache_control_if;
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_resp;
    logic       hit;
    logic       dirty_out;
    logic       tag_load;
    logic       valid_load;
    logic       dirty_load;
    logic       dirty_in;
    logic [1:0] writing;

    modport master (
        input  mem_read, mem_write, pmem_resp, hit, dirty_out,
        output mem_resp, pmem_read, pmem_write, tag_load, valid_load,
               dirty_load, dirty_in, writing
    );

    modport slave (
        output mem_read, mem_write, pmem_resp, hit, dirty_out,
        input  mem_resp, pmem_read, pmem_write, tag_load, valid_load,
               dirty_load, dirty_in, writing
    );
endinterface

// File: rtl/cache_control.sv
// Sequencer for a direct-mapped, write-back, write-allocate cache: hit/miss handling,
// victim writeback, line refill, and saturating hit/miss/writeback counters.
module cache_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_control_if.master      bus,
    input  logic                 perf_clear,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam logic [1:0] WR_FILL = 2'b00;
    localparam logic [1:0] WR_CPU  = 2'b01;
    localparam logic [1:0] WR_HOLD = 2'b10;

    state_t state;
    logic   req;
    logic   hit_evt;
    logic   miss_evt;
    logic   wb_evt;
    logic   alloc_done;
    logic   alloc_done_p1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                      input logic en);
        if (en && (v != {CNT_WIDTH{1'b1}}))
            return v + CNT_WIDTH'(1);
        return v;
    endfunction

    assign req = bus.mem_read | bus.mem_write;

    // Outputs are decoded from state and inputs, and all forced idle while rst_n is low.
    always_comb begin
        bus.mem_resp   = 1'b0;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.tag_load   = 1'b0;
        bus.valid_load = 1'b0;
        bus.dirty_load = 1'b0;
        bus.dirty_in   = 1'b0;
        bus.writing    = WR_HOLD;
        hit_evt        = 1'b0;
        miss_evt       = 1'b0;
        wb_evt         = 1'b0;
        alloc_done     = 1'b0;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        if (bus.hit) begin
                            bus.mem_resp = 1'b1;
                            // The re-check right after a refill is the same miss, not a new hit.
                            hit_evt      = ~alloc_done_p1;
                            if (bus.mem_write) begin
                                bus.writing    = WR_CPU;
                                bus.dirty_load = 1'b1;
                                bus.dirty_in   = 1'b1;
                            end
                        end else begin
                            miss_evt = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.dirty_load = 1'b1;
                        wb_evt         = 1'b1;
                    end
                end
                ALLOCATE: begin
                    bus.pmem_read = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.writing    = WR_FILL;
                        bus.tag_load   = 1'b1;
                        bus.valid_load = 1'b1;
                        bus.dirty_load = 1'b1;
                        alloc_done     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            alloc_done_p1 <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
            wb_count      <= '0;
        end else begin
            alloc_done_p1 <= alloc_done;
            unique case (state)
                IDLE:      if (miss_evt) state <= bus.dirty_out ? WRITEBACK : ALLOCATE;
                WRITEBACK: if (bus.pmem_resp) state <= ALLOCATE;
                ALLOCATE:  if (bus.pmem_resp) state <= IDLE;
                default:   state <= IDLE;
            endcase
            if (perf_clear) begin
                hit_count  <= '0;
                miss_count <= '0;
                wb_count   <= '0;
            end else begin
                hit_count  <= sat_inc(hit_count, hit_evt);
                miss_count <= sat_inc(miss_count, miss_evt);
                wb_count   <= sat_inc(wb_count, wb_evt);
            end
        end
    end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the direct-mapped, write-back, write-allocate cache datapath. It sits between the CPU-side request interface and physical memory. It decides hit/miss handling from the datapath's `hit`/`dirty_out` status and drives the datapath's load and `writing` controls. It also keeps saturating hit, miss and writeback counters for performance analysis.

## Interface
**Parameters**
- `CNT_WIDTH`, 32: width of each performance counter.

**Ports**
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mem_read`  in  1  CPU read request; held until `mem_resp`.
- `mem_write`  in  1  CPU write request; held until `mem_resp`. Both high together is treated as a write.
- `mem_resp`  out  1  one-cycle CPU completion pulse.
- `pmem_read`  out  1  physical-memory line read request.
- `pmem_write`  out  1  physical-memory line write request.
- `pmem_resp`  in  1  physical memory done. For reads, `pmem_rdata` is valid in this cycle.
- `hit`  in  1  datapath: valid line with matching tag.
- `dirty_out`  in  1  datapath: dirty bit of the indexed line.
- `tag_load`  out  1  write tag array at indexed set.
- `valid_load`  out  1  write valid bit (datapath input tied to 1).
- `dirty_load`  out  1  write dirty bit.
- `dirty_in`  out  1  dirty bit value to write.
- `writing`  out  2  data array source select:
  - 00: fill from `pmem_rdata`, all bytes.
  - 01: CPU write under `mem_byte_enable`.
  - 10: hold.
- `perf_clear`  in  1  synchronous clear of all counters.
- `hit_count`, `miss_count`, `wb_count`  out  CNT_WIDTH  saturating event counters.

## Operation
- States: IDLE, WRITEBACK, ALLOCATE.
- Default (every state unless listed):
  - all strobes 0, `dirty_in`=0, `writing`=10.
- IDLE, no request: stay in IDLE.
- IDLE, request with `hit`=1:
  - Read: `mem_resp`=1.
  - Write: `writing`=01, `dirty_load`=1, `dirty_in`=1, `mem_resp`=1.
  - Count a hit only if the previous cycle was not an ALLOCATE completion, so a refill re-check is not counted. Stay in IDLE.
- IDLE, request with `hit`=0:
  - Increment `miss_count`.
  - `dirty_out`=1: go to WRITEBACK. `dirty_out`=0: go to ALLOCATE.
- WRITEBACK:
  - `pmem_write`=1. The datapath presents the victim address {tag_out, index} and the line.
  - On `pmem_resp`: `dirty_load`=1, `dirty_in`=0, increment `wb_count`, go to ALLOCATE. Clearing dirty switches `pmem_address` back to the CPU address.
- ALLOCATE:
  - `pmem_read`=1.
  - On `pmem_resp`: `writing`=00, `tag_load`=1, `valid_load`=1, `dirty_load`=1, `dirty_in`=0, go to IDLE.
  - `writing`=00 is asserted only in the `pmem_resp` cycle.
- After ALLOCATE, IDLE re-evaluates the held request, which now hits. A write then merges the CPU bytes and sets dirty.
- Counters:
  - Increment by 1 per event; saturate at 2^CNT_WIDTH−1.
  - `perf_clear` has priority over increments in the same cycle.
  - Counters are unaffected by `mem_resp` timing.
- A request withdrawn mid-miss is a protocol violation. The FSM still completes the pmem transaction and returns to IDLE.
- `pmem_resp` while in IDLE is ignored.

## Timing
- Reset:
  - Any cycle with `rst_n`=0: state ← IDLE, counters ← 0.
  - All outputs are forced inactive combinationally in that cycle: strobes 0, `writing`=10, `mem_resp`=0.
  - Reset mid-WRITEBACK or mid-ALLOCATE aborts without a tag, valid or data write.
- Hit: `mem_resp` in the same cycle the request is first seen in IDLE (0-cycle latency). Array writes commit at that edge.
- Clean miss:
  - Request at cycle 0; ALLOCATE from cycle 1.
  - `pmem_resp` at cycle k ≥ 1; IDLE at k+1 with `mem_resp` at k+1.
- Dirty miss:
  - WRITEBACK from cycle 1; `pmem_resp` at cycle j.
  - ALLOCATE from j+1; `pmem_resp` at m; `mem_resp` at m+1.
- `pmem_read`/`pmem_write` are Moore outputs. They stay high through the `pmem_resp` cycle and drop the next cycle.

## Test plan
- Reset with `rst_n`=0 for 2 cycles, then a read to 0x0000_0040 with all arrays invalid:
  - miss; `pmem_read` cycles 1..k; `mem_resp` at k+1.
  - `miss_count`=1, `hit_count`=0.
- Repeat the read to 0x0000_0040 → `mem_resp` in the same cycle, no pmem activity, `hit_count`=1.
- Write to 0x0000_0044 with byte enable 0x0000_00F0 → same-cycle `mem_resp`, `writing`=01, `dirty_in`=1.
- Read 0x0000_0240 (same index, different tag, dirty victim):
  - `pmem_write` first; on its `pmem_resp`, `dirty_load`=1, `dirty_in`=0.
  - Then `pmem_read`; `wb_count`=1, `miss_count`=2.
- Pull `rst_n` low during ALLOCATE → `pmem_read` low that cycle, IDLE next, all counters 0, no `tag_load`.
- Preload `hit_count` to 2^32−1 via hits, then one more hit → counter stays 0xFFFF_FFFF. `perf_clear` with a hit in the same cycle → 0.
